motor_ramp_sequencer: RTL

Soft-start/soft-stop sequencer that sits between the NIOS command registers and the 8-bit DC-motor PWM speed controller. It accepts a target speed and direction, then steps the PWM `set_speed` value toward the target at a fixed rate. On a direction change it decelerates to zero, holds a dead-time dwell, flips the H-bridge direction and re-accelerates. An emergency-stop input overrides everything and forces the speed to zero.

---
 rtl/motor_pkg.sv | 7 +
 rtl/motor_ramp_sequencer_if.sv | 10 +
 rtl/ramp_tick_gen.sv | 20 ++
 rtl/motor_ramp_sequencer.sv | 94 +++++++++
 4 files changed

// File: rtl/motor_pkg.sv
// motor_pkg: shared motor-control types and constants
package motor_pkg;
  typedef enum logic [1:0] {HOLD, RAMP, DWELL, ESTOP} state_t;
  localparam int SPEED_W = 8;
  localparam logic DIR_FWD = 1'b0;
  localparam logic DIR_REV = 1'b1;
endpackage

// File: rtl/motor_ramp_sequencer_if.sv
// motor_ramp_sequencer_if: NIOS command handshake toward the ramp sequencer
interface motor_ramp_sequencer_if;
  import motor_pkg::*;
  logic               cmd_valid;
  logic               cmd_ready;
  logic [SPEED_W-1:0] cmd_speed;
  logic               cmd_dir;
  modport master(output cmd_valid, cmd_speed, cmd_dir, input cmd_ready);
  modport slave(input cmd_valid, cmd_speed, cmd_dir, output cmd_ready);
endinterface

// File: rtl/ramp_tick_gen.sv
// ramp_tick_gen: modulo-STEP_DIV counter emitting a one-cycle tick on wrap
module ramp_tick_gen #(
  parameter int STEP_DIV = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int W = $clog2(STEP_DIV + 1);
  localparam logic [W-1:0] LAST = W'(STEP_DIV - 1);
  logic [W-1:0] cnt_q, cnt_d;
  assign tick = enable && cnt_q == LAST;
  always_comb cnt_d = clear ? '0 : tick ? '0 : enable ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/motor_ramp_sequencer.sv
// motor_ramp_sequencer: soft-start/stop speed ramp with dead-time direction reversal and e-stop
module motor_ramp_sequencer
  import motor_pkg::*;
#(
  parameter int STEP_DIV     = 1000,
  parameter int DWELL_CYCLES = 50000
) (
  input  logic               clk,
  input  logic               rst,
  motor_ramp_sequencer_if.slave cmd,
  input  logic               estop,
  output logic [SPEED_W-1:0] set_speed,
  output logic               motor_dir,
  output logic               at_speed,
  output logic               busy
);
  localparam int DW = $clog2(DWELL_CYCLES + 1);
  localparam logic [DW-1:0] DLAST = DW'(DWELL_CYCLES - 1);
  state_t state_q, state_d;
  logic [SPEED_W-1:0] spd_q, spd_d, tgt_q, tgt_d, eff;
  logic dir_q, dir_d, tdir_q, tdir_d;
  logic [DW-1:0] dwl_q, dwl_d;
  logic tick, tclr, accept;
  assign cmd.cmd_ready = !estop && state_q != ESTOP;
  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  // a pending reversal first ramps to zero
  assign eff = (tdir_q == dir_q) ? tgt_q : '0;
  assign set_speed = spd_q;
  assign motor_dir = dir_q;
  assign at_speed = state_q == HOLD;
  assign busy = state_q == RAMP || state_q == DWELL;
  ramp_tick_gen #(.STEP_DIV(STEP_DIV)) u_tick (
    .clk   (clk),
    .rst   (rst),
    .clear (tclr),
    .enable(state_q == RAMP),
    .tick  (tick)
  );
  always_comb begin
    state_d = state_q;
    spd_d = spd_q;
    tgt_d = tgt_q;
    dir_d = dir_q;
    tdir_d = tdir_q;
    dwl_d = dwl_q;
    tclr = 1'b0;
    if (estop) begin
      state_d = ESTOP;
      spd_d = '0;
      tgt_d = '0;
      tdir_d = dir_q;
    end else if (state_q == ESTOP) begin
      state_d = HOLD;
    end else if (accept) begin
      tgt_d = cmd.cmd_speed;
      tdir_d = cmd.cmd_dir;
      tclr = 1'b1;
      dwl_d = '0;
      state_d = RAMP;
    end else if (state_q == RAMP) begin
      if (spd_q == eff) begin
        state_d = (tdir_q == dir_q) ? HOLD : DWELL;
        dwl_d = '0;
      end else if (tick) begin
        spd_d = (spd_q < eff) ? spd_q + 1'b1 : spd_q - 1'b1;
      end
    end else if (state_q == DWELL) begin
      if (dwl_q == DLAST) begin
        dir_d = tdir_q;
        tclr = 1'b1;
        state_d = RAMP;
      end else begin
        dwl_d = dwl_q + 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HOLD;
      spd_q <= '0;
      tgt_q <= '0;
      dir_q <= DIR_FWD;
      tdir_q <= DIR_FWD;
      dwl_q <= '0;
    end else begin
      state_q <= state_d;
      spd_q <= spd_d;
      tgt_q <= tgt_d;
      dir_q <= dir_d;
      tdir_q <= tdir_d;
      dwl_q <= dwl_d;
    end
  end
endmodule
